mmio_interval_timer: RTL and testbench



---
 rtl/mmio_interval_timer_pkg.sv | 19 +
 rtl/mmio_interval_timer_prescaler.sv | 33 +++
 rtl/mmio_interval_timer.sv | 135 +++++++++++++
 tb/tb_mmio_interval_timer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_interval_timer_pkg.sv
// Shared definitions for the MMIO interval timer: register map, CTRL bit
// positions and the bus handshake state encoding.
package mmio_timer_defs;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_e;

endpackage

// File: rtl/mmio_interval_timer_prescaler.sv
// Tick generator: one-cycle pulse every PRESCALE enabled cycles; the phase is
// held at 0 while disabled so the first tick lands PRESCALE cycles after enable.
module timer_prescaler #(
    parameter int PRESCALE = 625,
    parameter int PSBITS   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [PSBITS-1:0] PS_LAST = PSBITS'(PRESCALE - 1);

    logic [PSBITS-1:0] ps_q, ps_d;

    always_comb begin
        tick = enable && (ps_q == PS_LAST);
        ps_d = '0;
        if (enable && !tick) begin
            ps_d = ps_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/mmio_interval_timer.sv
// Memory-mapped 32-bit down-counting interval timer with a Read/Write/Ready
// level handshake and a registered level interrupt.
//
// state | meaning
// IDLE  | waiting for Read or Write; the access is performed on leaving IDLE
// ACK   | Ready high; held until both Read and Write drop
module mmio_interval_timer
    import mmio_timer_defs::*;
#(
    parameter int PRESCALE = 625,
    parameter int PSBITS   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Read,
    input  logic        Write,
    input  logic [1:0]  Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ready,
    output logic        Interrupt
);

    hs_state_e   state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [31:0] dout_q, dout_d;
    logic        exp_q, exp_d;
    logic        irq_q, irq_d;
    logic        tick;
    logic        accept;
    logic        wr_en;
    logic [31:0] rdata;

    timer_prescaler #(
        .PRESCALE(PRESCALE),
        .PSBITS  (PSBITS)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .enable(ctrl_q[CTRL_EN]),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;
        accept  = 1'b0;
        rdata   = '0;

        case (Address)
            REG_CTRL:  rdata = {29'd0, ctrl_q};
            REG_LOAD:  rdata = load_q;
            REG_COUNT: rdata = count_q;
            default:   rdata = {31'd0, exp_q};
        endcase

        case (state_q)
            IDLE: begin
                if (Read || Write) begin
                    accept  = 1'b1;
                    dout_d  = rdata;
                    state_d = ACK;
                end
            end
            default: begin
                if (!(Read || Write)) begin
                    state_d = IDLE;
                end
            end
        endcase

        wr_en = accept && Write;

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (ctrl_q[CTRL_AUTO]) begin
                count_d = load_q;
            end else begin
                ctrl_d[CTRL_EN] = 1'b0;
            end
        end

        // Bus writes override the tick update; EXP set still beats W1C below.
        if (wr_en) begin
            case (Address)
                REG_CTRL:  ctrl_d  = DataIn[2:0];
                REG_LOAD:  load_d  = DataIn;
                REG_COUNT: count_d = DataIn;
                default: begin
                    if (DataIn[0]) begin
                        exp_d = 1'b0;
                    end
                end
            endcase
        end

        if (tick && (count_q == '0)) begin
            exp_d = 1'b1;
        end

        irq_d = exp_q && ctrl_q[CTRL_IE];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            exp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            exp_q   <= exp_d;
            irq_q   <= irq_d;
        end
    end

    assign Ready     = (state_q == ACK);
    assign DataOut   = dout_q;
    assign Interrupt = irq_q;

endmodule

// File: tb/tb_mmio_interval_timer.sv
// Directed bench for mmio_interval_timer: two instances (PRESCALE 1 and 4) share
// the bus inputs; read data is checked through an expected-value queue.
module tb_mmio_interval_timer;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [1:0]  Address = 2'd0;
    logic [31:0] DataIn = 32'd0;
    logic [31:0] dout1, dout4;
    logic        rdy1, rdy4, irq1, irq4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    mmio_interval_timer #(.PRESCALE(1), .PSBITS(16)) u1 (
        .clock(clock), .reset(reset), .Read(Read), .Write(Write),
        .Address(Address), .DataIn(DataIn), .DataOut(dout1),
        .Ready(rdy1), .Interrupt(irq1)
    );

    mmio_interval_timer #(.PRESCALE(4), .PSBITS(16)) u4 (
        .clock(clock), .reset(reset), .Read(Read), .Write(Write),
        .Address(Address), .DataIn(DataIn), .DataOut(dout4),
        .Ready(rdy4), .Interrupt(irq4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit s4, output int lat);
        int i;
        lat = 99;
        i = 0;
        while (lat == 99 && i < 8) begin
            @(negedge clock);
            i++;
            if ((s4 ? rdy4 : rdy1) === 1'b1) lat = i;
        end
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, output int acc);
        int lat;
        Address = addr;
        DataIn  = data;
        Write   = 1'b1;
        wait_ready(1'b0, lat);
        acc = cyc;
        check("wr_latency", 32'(lat), 32'd1);
        Write = 1'b0;
        @(negedge clock);
    endtask

    task automatic bus_read(input bit s4, input logic [1:0] addr, input logic [31:0] exp,
                            input string tag);
        int  lat;
        sb_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
        Address = addr;
        Read    = 1'b1;
        wait_ready(s4, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        it = sb_q.pop_front();
        check(it.tag, s4 ? dout4 : dout1, it.exp);
        Read = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One-shot COUNT=3, PRESCALE=4: value after posedge j, CTRL written at c0.
    function automatic logic [31:0] oneshot_cnt(input int c0, input int j);
        int v;
        if (j < c0) return 32'd3;
        v = 3 - (j - c0) / 4;
        return (v < 0) ? 32'd0 : 32'(v);
    endfunction

    // Auto-reload LOAD=2, COUNT=0, PRESCALE=1: reloads on posedges c0+1, c0+4, ...
    function automatic logic [31:0] auto_cnt(input int c0, input int j);
        if (j <= c0) return 32'd0;
        return 32'(2 - ((j - c0 - 1) % 3));
    endfunction

    function automatic logic exp_after(input int c0, input int w, input int j);
        for (int e = w; e <= j; e++) begin
            if (e >= c0 + 1 && ((e - c0 - 1) % 3) == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        int a, c0, w;
        logic [31:0] ev;

        // Reset state
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_ready", {31'd0, rdy1}, 32'd0);
        check("rst_irq", {31'd0, irq1}, 32'd0);
        check("rst_dout", dout1, 32'd0);
        check("rst_irq4", {31'd0, irq4}, 32'd0);
        bus_read(1'b0, A_CTRL, 32'd0, "rst_ctrl");
        bus_read(1'b0, A_LOAD, 32'd0, "rst_load");
        bus_read(1'b0, A_COUNT, 32'd0, "rst_count");
        bus_read(1'b0, A_STATUS, 32'd0, "rst_status");

        // Handshake with Write held for three cycles
        Address = A_LOAD;
        DataIn  = 32'h0000_0005;
        Write   = 1'b1;
        check("hs_c0_ready", {31'd0, rdy1}, 32'd0);
        @(negedge clock);
        check("hs_c1_ready", {31'd0, rdy1}, 32'd1);
        DataIn = 32'h0000_0007;
        @(negedge clock);
        check("hs_c2_ready", {31'd0, rdy1}, 32'd1);
        @(negedge clock);
        check("hs_c3_ready", {31'd0, rdy1}, 32'd1);
        Write = 1'b0;
        @(negedge clock);
        check("hs_c4_ready", {31'd0, rdy1}, 32'd0);
        bus_read(1'b0, A_LOAD, 32'd5, "hs_load_once");

        // One-shot on the PRESCALE=4 instance
        do_reset();
        bus_write(A_COUNT, 32'd3, a);
        bus_write(A_CTRL, 32'b101, c0);
        for (int r = 0; r < 7; r++) begin
            bus_read(1'b1, A_COUNT, oneshot_cnt(c0, cyc), $sformatf("os_count%0d", r));
        end
        while (cyc <= c0 + 20) begin
            check($sformatf("os_irq_e%0d", cyc - c0), {31'd0, irq4},
                  (cyc >= c0 + 17) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        bus_read(1'b1, A_CTRL, 32'b100, "os_ctrl_en_clr");
        bus_read(1'b1, A_COUNT, 32'd0, "os_count_hold0");
        bus_read(1'b1, A_STATUS, 32'd1, "os_status_exp");

        // Auto-reload on the PRESCALE=1 instance
        do_reset();
        bus_write(A_LOAD, 32'd2, a);
        bus_write(A_COUNT, 32'd0, a);
        bus_write(A_CTRL, 32'b111, c0);
        check("ar_irq_first_low", {31'd0, irq1}, 32'd0);
        @(negedge clock);
        check("ar_irq_first_high", {31'd0, irq1}, 32'd1);
        for (int r = 0; r < 4; r++) begin
            bus_read(1'b0, A_COUNT, auto_cnt(c0, cyc), $sformatf("ar_count%0d", r));
        end
        for (int i = 0; i < 3 && ((cyc - c0) % 3) == 0; i++) @(negedge clock);
        bus_write(A_STATUS, 32'd1, w);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ar_w1c_irq%0d", i), {31'd0, irq1},
                  {31'd0, exp_after(c0, w, cyc - 1)});
            @(negedge clock);
        end

        // W1C landing on an expiry tick
        for (int i = 0; i < 3 && ((cyc - c0) % 3) != 0; i++) @(negedge clock);
        bus_write(A_STATUS, 32'd1, w);
        check("sim_w1c_on_expiry_edge", 32'((w - c0 - 1) % 3), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("sim_irq%0d", i), {31'd0, irq1},
                  {31'd0, exp_after(c0, w, cyc - 1)});
            @(negedge clock);
        end
        bus_read(1'b0, A_STATUS, 32'd1, "sim_status");

        // COUNT write on a tick cycle (PRESCALE=1 ticks every cycle)
        bus_write(A_COUNT, 32'hFFFF_FFFF, a);
        ev = 32'hFFFF_FFFF - 32'(cyc - a);
        bus_read(1'b0, A_COUNT, ev, "cw_count_first");
        ev = 32'hFFFF_FFFF - 32'(cyc - a);
        bus_read(1'b0, A_COUNT, ev, "cw_count_second");

        // Reset while running and while held in ACK
        Address = A_COUNT;
        Read    = 1'b1;
        @(negedge clock);
        check("rr_ack_before_reset", {31'd0, rdy1}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rr_ready_dropped", {31'd0, rdy1}, 32'd0);
        check("rr_irq_cleared", {31'd0, irq1}, 32'd0);
        check("rr_dout_cleared", dout1, 32'd0);
        reset = 1'b0;
        begin
            sb_t it;
            it.tag = "rr_reaccept_count";
            it.exp = 32'd0;
            sb_q.push_back(it);
            @(negedge clock);
            check("rr_reaccept_ready", {31'd0, rdy1}, 32'd1);
            it = sb_q.pop_front();
            check(it.tag, dout1, it.exp);
        end
        Read = 1'b0;
        @(negedge clock);
        bus_read(1'b0, A_CTRL, 32'd0, "rr_ctrl");
        bus_read(1'b0, A_LOAD, 32'd0, "rr_load");
        bus_read(1'b0, A_STATUS, 32'd0, "rr_status");
        bus_read(1'b0, A_COUNT, 32'd0, "rr_count");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
